// File: rtl/ex_mem_stage_if.sv
// EX-side bundle feeding the EX->MEM pipeline register.
// The master is the execute stage; the slave is the pipeline register that returns ex_ready.
interface ex_mem_stage_if #(
  parameter int unsigned REG_W = 5
);
  logic             ex_valid;
  logic [31:0]      ex_alu_result;
  logic             ex_carry;
  logic             ex_zero;
  logic             ex_gt;
  logic             ex_overflow;
  logic             ex_negative;
  logic             ex_set_flags;
  logic [REG_W-1:0] ex_rd;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic             ex_mem_write;
  logic [31:0]      ex_store_data;
  logic             ex_ready;

  modport master (
    output ex_valid, ex_alu_result, ex_carry, ex_zero, ex_gt, ex_overflow,
           ex_negative, ex_set_flags, ex_rd, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_store_data,
    input  ex_ready
  );

  modport slave (
    input  ex_valid, ex_alu_result, ex_carry, ex_zero, ex_gt, ex_overflow,
           ex_negative, ex_set_flags, ex_rd, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_store_data,
    output ex_ready
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register: holds on memory stall, squashes on flush, owns the
// architectural {N,Z,C,V,GT} flags, drives MEM->EX forwarding and counts stall cycles.
module ex_mem_stage #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  ex_mem_stage_if.slave    ex,
  input  logic             mem_stall,
  input  logic             flush,
  output logic             mem_valid,
  output logic [31:0]      mem_alu_result,
  output logic [REG_W-1:0] mem_rd,
  output logic             mem_reg_write,
  output logic             mem_mem_read,
  output logic             mem_mem_write,
  output logic [31:0]      mem_store_data,
  output logic [4:0]       flags,
  output logic             fwd_en,
  output logic [REG_W-1:0] fwd_rd,
  output logic [31:0]      fwd_value,
  output logic [CNT_W-1:0] stall_cycles
);

  logic       load_en;
  logic       flag_en;
  logic [4:0] flag_next;

  assign ex.ex_ready = ~mem_stall;

  // Flush only matters when the register is actually advancing; a stalled MEM
  // instruction is older than the flush point and must survive.
  assign load_en   = ~mem_stall & ~flush;
  assign flag_en   = load_en & ex.ex_valid & ex.ex_set_flags;
  assign flag_next = {ex.ex_negative, ex.ex_zero, ex.ex_carry, ex.ex_overflow, ex.ex_gt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid      <= 1'b0;
      mem_alu_result <= '0;
      mem_rd         <= '0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_store_data <= '0;
    end else if (!mem_stall) begin
      if (flush) begin
        // Bubble: control cleared, data fields left as they were.
        mem_valid     <= 1'b0;
        mem_reg_write <= 1'b0;
        mem_mem_read  <= 1'b0;
        mem_mem_write <= 1'b0;
      end else begin
        mem_valid      <= ex.ex_valid;
        mem_alu_result <= ex.ex_alu_result;
        mem_rd         <= ex.ex_rd;
        mem_store_data <= ex.ex_store_data;
        mem_reg_write  <= ex.ex_reg_write & ex.ex_valid;
        mem_mem_read   <= ex.ex_mem_read  & ex.ex_valid;
        mem_mem_write  <= ex.ex_mem_write & ex.ex_valid;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= '0;
    end else if (flag_en) begin
      flags <= flag_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (mem_stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

  // Loads have no value yet in MEM, and r0 is never a real producer.
  assign fwd_en    = mem_valid & mem_reg_write & ~mem_mem_read & (mem_rd != '0);
  assign fwd_rd    = mem_rd;
  assign fwd_value = mem_alu_result;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: vector table for single-cycle behaviour plus
// hand-written stall, flush, reset and saturation sequences.
module tb_ex_mem_stage;

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             mem_stall;
  logic             flush;
  logic             mem_valid;
  logic [31:0]      mem_alu_result;
  logic [REG_W-1:0] mem_rd;
  logic             mem_reg_write;
  logic             mem_mem_read;
  logic             mem_mem_write;
  logic [31:0]      mem_store_data;
  logic [4:0]       flags;
  logic             fwd_en;
  logic [REG_W-1:0] fwd_rd;
  logic [31:0]      fwd_value;
  logic [CNT_W-1:0] stall_cycles;

  int unsigned total;
  int unsigned bad;

  ex_mem_stage_if #(.REG_W(REG_W)) exif ();

  ex_mem_stage #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex             (exif.slave),
    .mem_stall      (mem_stall),
    .flush          (flush),
    .mem_valid      (mem_valid),
    .mem_alu_result (mem_alu_result),
    .mem_rd         (mem_rd),
    .mem_reg_write  (mem_reg_write),
    .mem_mem_read   (mem_mem_read),
    .mem_mem_write  (mem_mem_write),
    .mem_store_data (mem_store_data),
    .flags          (flags),
    .fwd_en         (fwd_en),
    .fwd_rd         (fwd_rd),
    .fwd_value      (fwd_value),
    .stall_cycles   (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             v;
    logic [31:0]      res;
    logic [REG_W-1:0] rd;
    logic             rw, mr, mw, fl, sf;
    logic [4:0]       nzcvg;
    logic [31:0]      sd;
    logic             e_v;
    logic [31:0]      e_res;
    logic [REG_W-1:0] e_rd;
    logic             e_rw, e_mr, e_mw;
    logic [31:0]      e_sd;
    logic             e_fwd;
    logic [4:0]       e_flags;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] res, input logic [REG_W-1:0] rd,
                       input logic rw, input logic mr, input logic mw,
                       input logic sf, input logic [4:0] nzcvg, input logic [31:0] sd);
    exif.ex_valid      = v;
    exif.ex_alu_result = res;
    exif.ex_rd         = rd;
    exif.ex_reg_write  = rw;
    exif.ex_mem_read   = mr;
    exif.ex_mem_write  = mw;
    exif.ex_set_flags  = sf;
    {exif.ex_negative, exif.ex_zero, exif.ex_carry, exif.ex_overflow, exif.ex_gt} = nzcvg;
    exif.ex_store_data = sd;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 64'(mem_valid), 64'd0);
    chk({tag, "_res"},   64'(mem_alu_result), 64'd0);
    chk({tag, "_rd"},    64'(mem_rd), 64'd0);
    chk({tag, "_ctl"},   64'({mem_reg_write, mem_mem_read, mem_mem_write}), 64'd0);
    chk({tag, "_sd"},    64'(mem_store_data), 64'd0);
    chk({tag, "_flags"}, 64'(flags), 64'd0);
    chk({tag, "_fwd"},   64'(fwd_en), 64'd0);
    chk({tag, "_cnt"},   64'(stall_cycles), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    mem_stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b0, 32'h0);

    //          v  res           rd rw mr mw fl sf nzcvg     sd             e_v e_res        e_rd rw mr mw e_sd           fwd flags
    vecs[0] = '{1, 32'h0000_002A, 5, 1, 0, 0, 0, 0, 5'b00000, 32'h0,         1, 32'h0000_002A, 5, 1, 0, 0, 32'h0,         1, 5'b00000};
    vecs[1] = '{1, 32'h0000_0000, 3, 1, 0, 0, 0, 1, 5'b01000, 32'h0,         1, 32'h0000_0000, 3, 1, 0, 0, 32'h0,         1, 5'b01000};
    vecs[2] = '{1, 32'h0000_0010, 4, 1, 0, 0, 0, 0, 5'b10111, 32'h0,         1, 32'h0000_0010, 4, 1, 0, 0, 32'h0,         1, 5'b01000};
    vecs[3] = '{1, 32'h0000_0099, 6, 1, 0, 1, 1, 1, 5'b10101, 32'h55,        0, 32'h0000_0010, 4, 0, 0, 0, 32'h0,         0, 5'b01000};
    vecs[4] = '{1, 32'h0000_0100, 7, 1, 1, 0, 0, 0, 5'b00000, 32'h0,         1, 32'h0000_0100, 7, 1, 1, 0, 32'h0,         0, 5'b01000};
    vecs[5] = '{1, 32'h0000_0200, 0, 1, 0, 0, 0, 0, 5'b00000, 32'h0,         1, 32'h0000_0200, 0, 1, 0, 0, 32'h0,         0, 5'b01000};
    vecs[6] = '{1, 32'h0000_0300, 2, 0, 0, 1, 0, 0, 5'b00000, 32'hDEADBEEF,  1, 32'h0000_0300, 2, 0, 0, 1, 32'hDEADBEEF,  0, 5'b01000};
    vecs[7] = '{0, 32'h0000_0400, 9, 1, 1, 1, 0, 1, 5'b11111, 32'h1234,      0, 32'h0000_0400, 9, 0, 0, 0, 32'h1234,      0, 5'b01000};
    vecs[8] = '{1, 32'h0000_0500, 1, 1, 0, 0, 0, 1, 5'b10011, 32'h0,         1, 32'h0000_0500, 1, 1, 0, 0, 32'h0,         1, 5'b10011};
    vecs[9] = '{0, 32'h0000_0600, 8, 1, 0, 1, 1, 0, 5'b00000, 32'h77,        0, 32'h0000_0500, 1, 0, 0, 0, 32'h0,         0, 5'b10011};

    #3;
    chk_all_zero("reset");
    do_reset();
    chk_all_zero("post_reset");
    chk("ready_idle", 64'(exif.ex_ready), 64'd1);

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].v, vecs[i].res, vecs[i].rd, vecs[i].rw, vecs[i].mr, vecs[i].mw,
            vecs[i].sf, vecs[i].nzcvg, vecs[i].sd);
      flush = vecs[i].fl;
      step();
      chk($sformatf("v%0d_valid", i), 64'(mem_valid), 64'(vecs[i].e_v));
      chk($sformatf("v%0d_res", i),   64'(mem_alu_result), 64'(vecs[i].e_res));
      chk($sformatf("v%0d_rd", i),    64'(mem_rd), 64'(vecs[i].e_rd));
      chk($sformatf("v%0d_ctl", i),   64'({mem_reg_write, mem_mem_read, mem_mem_write}),
          64'({vecs[i].e_rw, vecs[i].e_mr, vecs[i].e_mw}));
      chk($sformatf("v%0d_sd", i),    64'(mem_store_data), 64'(vecs[i].e_sd));
      chk($sformatf("v%0d_fwd", i),   64'(fwd_en), 64'(vecs[i].e_fwd));
      chk($sformatf("v%0d_fwdrd", i), 64'(fwd_rd), 64'(vecs[i].e_rd));
      chk($sformatf("v%0d_fwdval", i), 64'(fwd_value), 64'(vecs[i].e_res));
      chk($sformatf("v%0d_flags", i), 64'(flags), 64'(vecs[i].e_flags));
    end
    flush = 1'b0;

    // Asynchronous reset mid-stream: outputs clear without a clock edge.
    drive(1'b1, 32'hABCD, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 5'b11111, 32'h9);
    step();
    chk("pre_rst_valid", 64'(mem_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;

    // Stall holds MEM while EX presents a new value.
    drive(1'b1, 32'h11, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 5'b0, 32'h0);
    step();
    chk("stall_pre_res", 64'(mem_alu_result), 64'h11);
    drive(1'b1, 32'h22, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, 5'b00100, 32'h0);
    mem_stall = 1'b1;
    #1;
    chk("stall_ready", 64'(exif.ex_ready), 64'd0);
    for (int c = 1; c <= 4; c++) begin
      step();
      chk($sformatf("stall%0d_res", c), 64'(mem_alu_result), 64'h11);
      chk($sformatf("stall%0d_cnt", c), 64'(stall_cycles), 64'(c));
    end
    chk("stall_flags_hold", 64'(flags), 64'd0);
    mem_stall = 1'b0;
    #1;
    chk("release_ready", 64'(exif.ex_ready), 64'd1);
    chk("release_res_held", 64'(mem_alu_result), 64'h11);
    step();
    chk("release_res", 64'(mem_alu_result), 64'h22);
    chk("release_rd", 64'(mem_rd), 64'd6);
    chk("release_flags", 64'(flags), 64'b00100);
    chk("release_cnt", 64'(stall_cycles), 64'd4);

    // Flush during stall must not squash the held MEM store.
    drive(1'b1, 32'h77, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b0, 32'hCAFE);
    step();
    chk("st_mw", 64'(mem_mem_write), 64'd1);
    drive(1'b1, 32'h88, 5'd2, 1'b0, 1'b0, 1'b1, 1'b1, 5'b11000, 32'hF00D);
    mem_stall = 1'b1;
    flush = 1'b1;
    step();
    chk("stflush_valid", 64'(mem_valid), 64'd1);
    chk("stflush_mw", 64'(mem_mem_write), 64'd1);
    chk("stflush_res", 64'(mem_alu_result), 64'h77);
    chk("stflush_sd", 64'(mem_store_data), 64'hCAFE);
    chk("stflush_flags", 64'(flags), 64'b00100);
    chk("stflush_cnt", 64'(stall_cycles), 64'd5);
    mem_stall = 1'b0;
    step();
    chk("flush_valid", 64'(mem_valid), 64'd0);
    chk("flush_mw", 64'(mem_mem_write), 64'd0);
    chk("flush_res_hold", 64'(mem_alu_result), 64'h77);
    chk("flush_flags", 64'(flags), 64'b00100);
    flush = 1'b0;

    // Saturating stall counter.
    do_reset();
    mem_stall = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 14 || c == 15 || c == 16 || c == 20)
        chk($sformatf("sat%0d_cnt", c), 64'(stall_cycles), 64'(c > 15 ? 15 : c));
    end
    mem_stall = 1'b0;
    step();
    chk("sat_release_cnt", 64'(stall_cycles), 64'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
